grf_scoreboard: RTL and testbench
=================================

Name: grf_scoreboard

Overview:
- Parametrised general register file for the pipelined CPU with configurable read-port count and two write ports (A: main writeback, B: secondary/late writeback).
- Write-through bypass from same-cycle writes, so decode sees fresh operands without external forwarding.
- Per-register outstanding-write scoreboard (saturating counters) that drives decode stalls.
- Sits in the ID stage; writes arrive from the WB stage.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports
- CNT_W, 2, width of each per-register outstanding-write counter
- BYPASS, 1, 1 = same-cycle write data visible on read ports; 0 = reads show stored value only

Ports:
- clk  in  1  clock
- reset  in  1  reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W]
- rd_pending  out  NUM_RD  port i address has an outstanding producer
- wa_we  in  1  write port A enable
- wa_addr  in  ADDR_W  write port A address
- wa_data  in  DATA_W  write port A data
- wb_we  in  1  write port B enable
- wb_addr  in  ADDR_W  write port B address
- wb_data  in  DATA_W  write port B data
- issue_valid  in  1  decode issues an instruction that will write issue_addr
- issue_addr  in  ADDR_W  destination of the issuing instruction
- issue_ready  out  1  issue accepted this cycle
- any_pending  out  1  some register has cnt != 0

Behaviour:
- Clock and reset: reset is synchronous, active-high; clk is the clock.
- Reset clears all registers to 0 and all counters to 0. After reset: rd_data = 0, rd_pending = 0, any_pending = 0, issue_ready = 1.
- Register 0:
  - Reads always return 0 and report not pending.
  - Writes to 0 are ignored and never change a counter.
  - An issue to 0 is accepted (issue_ready = 1) with no counter change.
- Writes take effect at posedge.
  - If wa_we and wb_we target the same nonzero address, port A data is stored.
- Reads are combinational.
  - BYPASS = 1: if wa_we and wa_addr == rd_addr (nonzero), return wa_data; else the same check against port B returns wb_data; else the stored value.
  - BYPASS = 0: return the stored value only.
- Counter update per nonzero register r, each posedge:
  - cnt_next = cnt + inc - dec.
  - inc = 1 if an issue to r is accepted.
  - dec = number of write ports (0..2) with we set and addr == r.
  - The result floors at 0; a write with no outstanding producer is legal.
- issue_ready = !issue_valid || issue_addr == 0 || cnt[issue_addr] - dec(issue_addr) < 2**CNT_W - 1.
  - Net counter value is used: a same-cycle write frees a slot.
  - Rejected issue: no counter change; the requester holds issue_valid.
- rd_pending[i]:
  - BYPASS = 1: (cnt[rd_addr_i] - dec(rd_addr_i)) > 0, floored at 0. The completing write is already bypassed.
  - BYPASS = 0: cnt[rd_addr_i] > 0.
  - A same-cycle issue does not affect rd_pending.
- Issue and write to the same register in the same cycle: the counter changes by +1 - dec and stays pending if the result is > 0.
- any_pending: OR of all counters != 0, registered value (pre-update).
- Reset asserted mid-operation overrides all writes and issues that cycle.

Decomposition:
- Shared package (grf_pkg):
  - DATA_W / ADDR_W defaults
  - ZERO_REG = 0 constant
  - Helper function for slicing packed port vectors
- Sub-module grf_pend_cnt: a single saturating up/down counter (inc, dec[1:0], full flag), instantiated per register by generate.
- Storage, bypass mux and the issue_ready logic stay in grf_scoreboard.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every rd_data = 0, rd_pending = 0, any_pending = 0.
- Issue $5; next cycle read $5 -> rd_pending = 1. Write wa $5 = 0x1234_5678 while reading $5 (BYPASS = 1) -> rd_data = 0x12345678, rd_pending = 0. Next cycle any_pending = 0.
- wa_we and wb_we both to $7 with data 0xAAAA0000 / 0x0000BBBB -> same-cycle read and next-cycle stored value = 0xAAAA0000.
- With CNT_W = 2, issue $9 three times -> cnt = 3. Fourth issue -> issue_ready = 0, cnt stays 3. Repeat the fourth issue together with wa write $9 -> issue_ready = 1, cnt stays 3.
- Write wa $0 = 0xFFFF_FFFF and issue $0 -> read $0 = 0, rd_pending = 0, issue_ready = 1.
- Issue $3 twice, then assert reset together with wa write $3 = 0x55 -> after the edge, $3 reads 0, rd_pending = 0, any_pending = 0.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared definitions for the general register file / scoreboard slice.
//   DATA_W_DEFAULT / ADDR_W_DEFAULT : default register width and address width
//   ZERO_REG                        : hard-wired zero register index
//   lane_lo()                       : low bit index of lane 'lane' in a packed
//                                     vector of 'width'-bit lanes
package grf_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 5;
  localparam int ZERO_REG       = 0;

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/grf_pend_cnt.sv
// Outstanding-write counter for one register.
//   clk, reset : clock, synchronous active-high reset (clears the count)
//   inc        : an issue targeting this register was accepted
//   dec        : number of write ports (0..2) completing to this register
//   full       : net count (count minus completing writes) cannot take another issue
//   busy       : stored count is nonzero
//   net_busy   : count minus completing writes, floored at 0, is nonzero
module grf_pend_cnt
  import grf_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic [1:0] dec,
  output logic       full,
  output logic       busy,
  output logic       net_busy
);

  // Two extra bits so cnt + inc and the dec compare never wrap.
  localparam int            EW    = CNT_W + 2;
  localparam logic [EW-1:0] MAX_E = EW'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [EW-1:0]    cnt_e;
  logic [EW-1:0]    dec_e;
  logic [EW-1:0]    net_e;
  logic [EW-1:0]    sum_e;
  logic [EW-1:0]    upd_e;

  always_comb begin
    cnt_e = EW'(cnt_reg);
    dec_e = EW'(dec);
    sum_e = cnt_e + EW'(inc);
    // Net value seen by decode: completing writes already retire producers.
    net_e = (cnt_e >= dec_e) ? (cnt_e - dec_e) : '0;
    // Write without an outstanding producer is legal, so floor at zero.
    upd_e = (sum_e >= dec_e) ? (sum_e - dec_e) : '0;
    cnt_next = (upd_e > MAX_E) ? CNT_W'(MAX_E) : CNT_W'(upd_e);
    full     = (net_e >= MAX_E);
    busy     = (cnt_reg != '0);
    net_busy = (net_e != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/grf_scoreboard.sv
// General register file with write-through bypass and per-register
// outstanding-write scoreboard for the ID stage.
//   clk, reset          : clock, synchronous active-high reset
//   rd_addr / rd_data   : NUM_RD combinational read ports (packed lanes)
//   rd_pending          : read address still has an outstanding producer
//   wa_* / wb_*         : write ports A (main WB) and B (late WB); A wins on collision
//   issue_valid/addr    : decode issues an instruction writing issue_addr
//   issue_ready         : issue accepted this cycle
//   any_pending         : some register has a nonzero stored count
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     wa_we,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_we,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     issue_ready,
  output logic                     any_pending
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  full;
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  net_busy;

  // Storage: port B first so port A overrides on an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wb_we && wb_addr != ZERO) begin
        mem[wb_addr] <= wb_data;
      end
      if (wa_we && wa_addr != ZERO) begin
        mem[wa_addr] <= wa_data;
      end
    end
  end

  // One counter per nonzero register; register 0 never pends.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cnt
    if (gi == ZERO_REG) begin : g_zero
      assign full[gi]     = 1'b0;
      assign busy[gi]     = 1'b0;
      assign net_busy[gi] = 1'b0;
    end else begin : g_reg
      logic       a_hit;
      logic       b_hit;
      logic       inc_r;
      logic [1:0] dec_r;

      assign a_hit = wa_we && (wa_addr == ADDR_W'(gi));
      assign b_hit = wb_we && (wb_addr == ADDR_W'(gi));
      assign dec_r = {1'b0, a_hit} + {1'b0, b_hit};
      assign inc_r = issue_valid && (issue_addr == ADDR_W'(gi)) && !full[gi];

      grf_pend_cnt #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (inc_r),
        .dec      (dec_r),
        .full     (full[gi]),
        .busy     (busy[gi]),
        .net_busy (net_busy[gi])
      );
    end
  end

  // full[] already accounts for same-cycle writes, so a completing write frees a slot.
  assign issue_ready = !issue_valid || (issue_addr == ZERO) || !full[issue_addr];
  assign any_pending = |busy;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;

    assign ra = rd_addr[lane_lo(gi, ADDR_W) +: ADDR_W];

    always_comb begin
      val = mem[ra];
      if (ra == ZERO) begin
        val = '0;
      end else if (BYPASS != 0 && wa_we && wa_addr == ra) begin
        val = wa_data;
      end else if (BYPASS != 0 && wb_we && wb_addr == ra) begin
        val = wb_data;
      end
    end

    assign rd_data[lane_lo(gi, DATA_W) +: DATA_W] = val;
    // With bypass the completing write already delivers the data, so use the net count.
    assign rd_pending[gi] = (BYPASS != 0) ? net_busy[ra] : busy[ra];
  end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Randomized + directed bench for grf_scoreboard (default parameters).
// The driver applies one input vector per cycle and queues the expected
// outputs computed from a plain array model; a monitor pops and compares.
module tb_grf_scoreboard;

  localparam int MAXC = 3;  // 2**CNT_W - 1

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pending;
  logic        wa_we;
  logic [4:0]  wa_addr;
  logic [31:0] wa_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        issue_ready;
  logic        any_pending;

  grf_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_pending  (rd_pending),
    .wa_we       (wa_we),
    .wa_addr     (wa_addr),
    .wa_data     (wa_data),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .any_pending (any_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  pend;
    logic        ready;
    logic        anyp;
    int          id;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_id  = 0;

  // Reference model state.
  logic [31:0] m_reg [32];
  int          m_cnt [32];

  function automatic int dec_of(input int r);
    int d = 0;
    if (r == 0) return 0;
    if (wa_we && int'(wa_addr) == r) d++;
    if (wb_we && int'(wb_addr) == r) d++;
    return d;
  endfunction

  function automatic int net_of(input int r);
    int n = m_cnt[r] - dec_of(r);
    return (n < 0) ? 0 : n;
  endfunction

  function automatic logic [31:0] rd_exp(input int a);
    if (a == 0) return 32'h0;
    if (wa_we && int'(wa_addr) == a) return wa_data;
    if (wb_we && int'(wb_addr) == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic logic ready_exp();
    if (!issue_valid || issue_addr == 5'd0) return 1'b1;
    return net_of(int'(issue_addr)) < MAXC;
  endfunction

  function automatic logic anyp_exp();
    for (int r = 0; r < 32; r++) if (m_cnt[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_reg[r] = 32'h0;
      m_cnt[r] = 0;
    end
  endtask

  // Applied at the clock edge with the inputs that were sampled there.
  task automatic model_update();
    int  nc [32];
    bit  acc;
    if (reset) begin
      model_clear();
      return;
    end
    acc = issue_valid && issue_addr != 5'd0 && ready_exp();
    for (int r = 1; r < 32; r++) begin
      nc[r] = m_cnt[r] + ((acc && int'(issue_addr) == r) ? 1 : 0) - dec_of(r);
      if (nc[r] < 0) nc[r] = 0;
    end
    for (int r = 1; r < 32; r++) m_cnt[r] = nc[r];
    if (wb_we && wb_addr != 5'd0) m_reg[wb_addr] = wb_data;
    if (wa_we && wa_addr != 5'd0) m_reg[wa_addr] = wa_data;
  endtask

  task automatic cyc(input bit rst, input bit iv, input int ia,
                     input bit ae, input int aa, input logic [31:0] ad,
                     input bit be, input int ba, input logic [31:0] bd,
                     input int r0, input int r1);
    exp_t e;
    reset       = rst;
    issue_valid = iv;
    issue_addr  = 5'(ia);
    wa_we       = ae;
    wa_addr     = 5'(aa);
    wa_data     = ad;
    wb_we       = be;
    wb_addr     = 5'(ba);
    wb_data     = bd;
    rd_addr     = {5'(r1), 5'(r0)};
    e.data  = {rd_exp(r1), rd_exp(r0)};
    e.pend  = {net_of(r1) > 0, net_of(r0) > 0};
    e.ready = ready_exp();
    e.anyp  = anyp_exp();
    e.id    = n_id;
    n_id++;
    q.push_back(e);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rd2(input int r0, input int r1);
    cyc(0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, r0, r1);
  endtask

  function automatic int rnd_addr();
    if ($urandom_range(3) == 0) return int'($urandom_range(31));
    return int'($urandom_range(7));
  endfunction

  // Monitor: one comparison set per presented vector, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (rd_data !== e.data) begin
          n_err++;
          $display("FAIL rd_data vec %0d: got %h exp %h", e.id, rd_data, e.data);
        end
        if (rd_pending !== e.pend) begin
          n_err++;
          $display("FAIL rd_pending vec %0d: got %b exp %b", e.id, rd_pending, e.pend);
        end
        if (issue_ready !== e.ready) begin
          n_err++;
          $display("FAIL issue_ready vec %0d: got %b exp %b", e.id, issue_ready, e.ready);
        end
        if (any_pending !== e.anyp) begin
          n_err++;
          $display("FAIL any_pending vec %0d: got %b exp %b", e.id, any_pending, e.anyp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    issue_valid = 1'b0; issue_addr = '0;
    wa_we = 1'b0; wa_addr = '0; wa_data = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    rd_addr = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;

    // Reset state across every address.
    for (int a = 0; a < 32; a++) rd2(a, 31 - a);

    // Issue, pending, then completing write with bypass.
    cyc(0, 1, 5, 0, 0, 32'h0, 0, 0, 32'h0, 5, 0);
    rd2(5, 5);
    cyc(0, 0, 0, 1, 5, 32'h1234_5678, 0, 0, 32'h0, 5, 0);
    rd2(5, 0);

    // Dual write collision: port A data wins.
    cyc(0, 0, 0, 1, 7, 32'hAAAA_0000, 1, 7, 32'h0000_BBBB, 7, 7);
    rd2(7, 5);

    // Counter saturation and slot freed by a same-cycle write.
    for (int k = 0; k < 3; k++) cyc(0, 1, 9, 0, 0, 32'h0, 0, 0, 32'h0, 9, 0);
    cyc(0, 1, 9, 0, 0, 32'h0, 0, 0, 32'h0, 9, 0);
    cyc(0, 1, 9, 1, 9, 32'hCAFE_0009, 0, 0, 32'h0, 9, 0);
    cyc(0, 1, 9, 0, 0, 32'h0, 0, 0, 32'h0, 9, 9);
    cyc(0, 0, 0, 1, 9, 32'h9, 1, 9, 32'h99, 9, 0);

    // Register 0 is immune to writes and issues.
    cyc(0, 1, 0, 1, 0, 32'hFFFF_FFFF, 1, 0, 32'h1, 0, 0);
    rd2(0, 9);

    // Reset mid-operation overrides a write and pending issues.
    cyc(0, 1, 3, 0, 0, 32'h0, 0, 0, 32'h0, 3, 0);
    cyc(0, 1, 3, 0, 0, 32'h0, 0, 0, 32'h0, 3, 0);
    cyc(1, 0, 0, 1, 3, 32'h55, 0, 0, 32'h0, 3, 0);
    rd2(3, 7);

    // Randomized traffic biased towards a few registers for collisions.
    for (int n = 0; n < 2000; n++) begin
      cyc($urandom_range(199) == 0, $urandom_range(1) == 1, rnd_addr(),
          $urandom_range(9) < 4, rnd_addr(), $urandom(),
          $urandom_range(9) < 4, rnd_addr(), $urandom(),
          rnd_addr(), rnd_addr());
    end
    rd2(0, 0);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d queued vectors exp 0", q.size());
    end
    if (n_vec != n_id) begin
      n_err++;
      $display("FAIL vector_count: got %0d exp %0d", n_vec, n_id);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
